l2_arbiter: RTL and testbench

Two-requester arbiter that shares the single L2 / physical-memory line port between the I-cache and the D-cache miss paths. Each cache presents an `l2_go_t` request (read or write of one 256-bit line) and receives an `l2_ret_t` response. The arbiter grants one requester at a time, forwards its request to the L2, routes the response back, and uses round-robin on simultaneous requests. It sits between the two L1 caches and the L2 cache in the `cpu` top level.

---
 rtl/l2_arbiter.sv | 123 ++++++++++++
 tb/tb_l2_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the single L2 line port between the I-cache and D-cache miss paths.
// Request latency 1 cycle, response 0 cycles; a losing requester holds its request until granted.
package l2_arbiter_pkg;
  localparam int L2_ADDR_W = 32;
  localparam int L2_LINE_W = 256;

  typedef struct packed {
    logic                 mem_read;
    logic                 mem_write;
    logic [L2_ADDR_W-1:0] mem_address;
    logic [L2_LINE_W-1:0] mem_wdata;
  } l2_go_t;

  typedef struct packed {
    logic                 mem_resp;
    logic [L2_LINE_W-1:0] mem_rdata;
  } l2_ret_t;
endpackage

module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W = L2_ADDR_W,
  parameter int LINE_W = L2_LINE_W
) (
  input  logic    clk,
  input  logic    rst_n,
  input  l2_go_t  i_go,
  output l2_ret_t i_ret,
  input  l2_go_t  d_go,
  output l2_ret_t d_ret,
  output l2_go_t  l2_go,
  input  l2_ret_t l2_ret,
  output logic    grant_i,
  output logic    grant_d
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_e;

  // last_grant encoding: 0 = I-cache, 1 = D-cache
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   i_act, d_act;

  logic              rd_sel, wr_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [LINE_W-1:0] wdata_sel;
  logic [LINE_W-1:0] rdata;

  assign i_act = i_go.mem_read | i_go.mem_write;
  assign d_act = d_go.mem_read | d_go.mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= OWN_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins
        if (i_act && (!d_act || last_q == OWN_D)) begin
          state_d = GNT_I;
        end else if (d_act) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (l2_ret.mem_resp) begin
          state_d = DONE;
          last_d  = OWN_I;
        end
      end
      GNT_D: begin
        if (l2_ret.mem_resp) begin
          state_d = DONE;
          last_d  = OWN_D;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant_i = (state_q == GNT_I);
  assign grant_d = (state_q == GNT_D);

  // Request mux is steered only by registered state, never by the request itself
  always_comb begin
    rd_sel    = 1'b0;
    wr_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (grant_i) begin
      rd_sel    = i_go.mem_read;
      wr_sel    = i_go.mem_write;
      addr_sel  = i_go.mem_address;
      wdata_sel = i_go.mem_wdata;
    end else if (grant_d) begin
      rd_sel    = d_go.mem_read;
      wr_sel    = d_go.mem_write;
      addr_sel  = d_go.mem_address;
      wdata_sel = d_go.mem_wdata;
    end
  end

  assign l2_go = {rd_sel, wr_sel, addr_sel, wdata_sel};

  assign rdata = l2_ret.mem_rdata;
  assign i_ret = {l2_ret.mem_resp & grant_i, rdata};
  assign d_ret = {l2_ret.mem_resp & grant_d, rdata};

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected grants/responses queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_l2_arbiter;
  import l2_arbiter_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  l2_go_t  i_go, d_go, l2_go;
  l2_ret_t i_ret, d_ret, l2_ret;
  l2_ret_t env_ret, man_ret;
  logic    grant_i, grant_d;
  logic    auto_en = 1'b1;
  int      lat = 3;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_go    (i_go),
    .i_ret   (i_ret),
    .d_go    (d_go),
    .d_ret   (d_ret),
    .l2_go   (l2_go),
    .l2_ret  (l2_ret),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  typedef struct { logic who; l2_go_t go; int gap; } gexp_t;
  typedef struct { logic who; logic [255:0] rdata; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    resp_count = 0;
  int    env_cnt = 0;

  function automatic logic [255:0] rd_of(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic l2_go_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [255:0] w);
    l2_go_t g;
    g.mem_read    = rd;
    g.mem_write   = wr;
    g.mem_address = a;
    g.mem_wdata   = w;
    return g;
  endfunction

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic bad(input string name);
    n_chk++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic push_g(input logic who, input l2_go_t go, input int gap);
    gexp_t e;
    e.who = who; e.go = go; e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic push_r(input logic who, input logic [255:0] rdata);
    rexp_t e;
    e.who = who; e.rdata = rdata;
    rq.push_back(e);
  endtask

  task automatic pop_resp(input logic who, input logic [255:0] rdata);
    rexp_t e;
    if (rq.size() == 0) begin
      bad("unexpected response");
    end else begin
      e = rq.pop_front();
      chk("resp owner", who, e.who);
      chk("resp rdata", rdata, e.rdata);
    end
  endtask

  task automatic wait_resp(input int n);
    int t = 0;
    while (resp_count < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (resp_count < n) bad("response timeout");
  endtask

  // L2 model: answers a forwarded request lat cycles into the grant, for one cycle
  assign l2_ret = auto_en ? env_ret : man_ret;

  initial begin
    env_ret = '0;
    forever begin
      @(posedge clk);
      #1;
      if (env_ret.mem_resp) begin
        env_ret.mem_resp = 1'b0;
        env_cnt = 0;
      end else if (l2_go.mem_read | l2_go.mem_write) begin
        env_cnt++;
        if (env_cnt > lat) begin
          env_ret = {1'b1, rd_of(l2_go.mem_address)};
          resp_count++;
          env_cnt = 0;
        end
      end else begin
        env_cnt = 0;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Monitor
  logic  prev_g = 1'b0;
  gexp_t cur;
  int    last_resp_cyc = -100;

  always @(negedge clk) begin
    gexp_t e;
    if ((grant_i | grant_d) && !prev_g) begin
      if (gq.size() == 0) begin
        bad("unexpected grant");
      end else begin
        e = gq.pop_front();
        cur = e;
        chk("grant owner", grant_d, e.who);
        if (e.gap >= 0) chk("idle gap", cyc - last_resp_cyc - 1, e.gap);
      end
    end
    if (grant_i | grant_d) begin
      chk("grant onehot", grant_i & grant_d, 1'b0);
      chk("l2_go fwd", l2_go, cur.go);
    end
    if (i_ret.mem_resp) pop_resp(1'b0, i_ret.mem_rdata);
    if (d_ret.mem_resp) pop_resp(1'b1, d_ret.mem_rdata);
    if (i_ret.mem_resp | d_ret.mem_resp) last_resp_cyc = cyc;
    prev_g = grant_i | grant_d;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    man_ret = '0;
    rst_n = 1'b0;
    i_go = mk(1'b1, 1'b0, 32'h0000_3000, '0);
    d_go = mk(1'b0, 1'b1, 32'h0000_4000, {8{32'hDEADBEEF}});
    repeat (3) @(negedge clk);
    chk("rst l2 rd", l2_go.mem_read, 1'b0);
    chk("rst l2 wr", l2_go.mem_write, 1'b0);
    chk("rst grant_i", grant_i, 1'b0);
    chk("rst grant_d", grant_d, 1'b0);
    chk("rst i_resp", i_ret.mem_resp, 1'b0);
    chk("rst d_resp", d_ret.mem_resp, 1'b0);

    // Persistent tie from reset: D, I, D with two dead cycles between
    push_g(1'b1, d_go, -1);
    push_r(1'b1, rd_of(32'h0000_4000));
    push_g(1'b0, i_go, 2);
    push_r(1'b0, rd_of(32'h0000_3000));
    push_g(1'b1, d_go, 2);
    push_r(1'b1, rd_of(32'h0000_4000));
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first grant d", grant_d, 1'b1);
    wait_resp(3);
    @(negedge clk);
    #2 i_go = '0; d_go = '0;
    repeat (4) @(negedge clk);

    // Single I read, L2 answers 5 cycles into the grant
    lat = 5;
    #2 i_go = mk(1'b1, 1'b0, 32'h0000_1000, '0);
    push_g(1'b0, i_go, -1);
    push_r(1'b0, rd_of(32'h0000_1000));
    @(negedge clk);
    chk("i addr cycle1", l2_go.mem_address, 32'h0000_1000);
    chk("i grant cycle1", grant_i, 1'b1);
    wait_resp(4);
    @(negedge clk);
    #2 i_go = '0;
    repeat (5) @(negedge clk);

    // D arrives while I owns the port
    lat = 4;
    #2 i_go = mk(1'b1, 1'b0, 32'h0000_5000, '0);
    push_g(1'b0, i_go, -1);
    push_r(1'b0, rd_of(32'h0000_5000));
    @(negedge clk);
    #2 d_go = mk(1'b1, 1'b0, 32'h0000_6000, '0);
    push_g(1'b1, d_go, 2);
    push_r(1'b1, rd_of(32'h0000_6000));
    wait_resp(5);
    @(negedge clk);
    #2 i_go = '0;
    wait_resp(6);
    @(negedge clk);
    #2 d_go = '0;
    repeat (5) @(negedge clk);

    // Spurious L2 response while idle
    #2 auto_en = 1'b0;
    man_ret = {1'b1, {8{32'hCAFEF00D}}};
    #1;
    chk("spur i_resp", i_ret.mem_resp, 1'b0);
    chk("spur d_resp", d_ret.mem_resp, 1'b0);
    chk("spur i_rdata", i_ret.mem_rdata, {8{32'hCAFEF00D}});
    chk("spur d_rdata", d_ret.mem_rdata, {8{32'hCAFEF00D}});
    @(negedge clk);
    chk("spur grant_i", grant_i, 1'b0);
    chk("spur grant_d", grant_d, 1'b0);
    chk("spur l2_go", l2_go, '0);
    #2 man_ret = '0;
    repeat (2) @(negedge clk);

    // Reset pulse during a D grant, then a late L2 response
    #2 d_go = mk(1'b0, 1'b1, 32'h0000_7000, {8{32'h0BADF00D}});
    push_g(1'b1, d_go, -1);
    @(negedge clk);
    chk("d granted", grant_d, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async l2_go", l2_go, '0);
    chk("async grant_d", grant_d, 1'b0);
    chk("async grant_i", grant_i, 1'b0);
    d_go = '0;
    man_ret = {1'b1, {8{32'h1234_5678}}};
    #1;
    chk("late d_resp rst", d_ret.mem_resp, 1'b0);
    chk("late i_resp rst", i_ret.mem_resp, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("late d_resp", d_ret.mem_resp, 1'b0);
    chk("late i_resp", i_ret.mem_resp, 1'b0);
    chk("late grant_d", grant_d, 1'b0);
    chk("late grant_i", grant_i, 1'b0);
    #2 man_ret = '0;
    repeat (3) @(negedge clk);

    chk("grant queue empty", gq.size(), 0);
    chk("resp queue empty", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
